mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL have these ports; widths use the shared RegisterBus (32) and RegisterAddressBus (5) definitions:
  clk  in  1  single clock, all state on rising edge
  rst  in  1  asynchronous, active-low reset
  mem_wdata  in  32  ALU result or store data from the EX/MEM register
  mem_wd  in  5  destination register address
  mem_wreg  in  1  register write enable
  mem_op  in  3  memory op code (NONE/LW/LB/LBU/SW/SB)
  mem_addr  in  32  effective byte address
  bus_req  out  1  data-bus request, registered
  bus_we  out  1  write strobe, registered
  bus_addr  out  32  word address, registered, bits [1:0]=00
  bus_sel  out  4  byte lanes, registered
  bus_wdata  out  32  store data, registered
  bus_ready  in  1  bus completion, valid while bus_req=1
  bus_rdata  in  32  read data, valid with bus_ready
  wb_wdata  out  32  result to write-back, registered
  wb_wd  out  5  write-back address, registered
  wb_wreg  out  1  write-back enable, registered
  stallreq  out  1  combinational stall request to upstream
  align_err  out  1  one-cycle misalignment pulse, registered

Function
REQ-002 States SHALL be IDLE and ACCESS.
REQ-003 IDLE, mem_op=NONE: stallreq=0; wb_* SHALL capture mem_wdata/mem_wd/mem_wreg at the next edge (1-cycle latency).
REQ-004 IDLE, valid memory op: stallreq=1; next edge SHALL load bus_* (bus_req=1), set wb_wreg=0 (bubble), go to ACCESS.
REQ-005 ACCESS: stallreq SHALL equal !bus_ready; bus_* SHALL hold stable until bus_ready=1.
REQ-006 ACCESS with bus_ready=1: next edge SHALL clear bus_req and bus_we, load wb_* with the result, return to IDLE; upstream advances on that same edge, so the op is never reissued.
REQ-007 ACCESS with bus_ready=0: wb_wreg SHALL stay 0; wait is unbounded.
REQ-008 Lanes are big-endian: addr[1:0]=00 -> bus_sel=1000 / rdata[31:24], 01 -> 0100, 10 -> 0010, 11 -> 0001; word ops SHALL use 1111.
REQ-009 SB SHALL replicate mem_wdata[7:0] to all four bytes of bus_wdata; SW SHALL drive mem_wdata unchanged.
REQ-010 LW SHALL return bus_rdata; LB SHALL sign-extend the selected byte; LBU SHALL zero-extend it.
REQ-011 For loads, wb_wd=mem_wd and wb_wreg=mem_wreg; for stores, wb_wreg SHALL be 0.
REQ-012 Undefined mem_op encodings SHALL be treated as NONE.

Reset
REQ-013 rst=0 SHALL immediately force IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_sel=0, bus_wdata=0, wb_wdata=ZeroWord, wb_wd=NOPRegisterAddress, wb_wreg=WriteDisable, align_err=0.
REQ-014 Reset during ACCESS SHALL abandon the transfer with no write-back; a late bus_ready SHALL be ignored.

Configuration
REQ-015 With MEM_ALIGN_CHECK_EN defined, LW/SW with mem_addr[1:0]!=00 SHALL cause no bus access and no stall; next edge sets align_err=1 for one cycle and wb_wreg=0.
REQ-016 Without MEM_ALIGN_CHECK_EN, word ops SHALL ignore mem_addr[1:0] and align_err SHALL be tied to 0.

Structure
REQ-017 mem_op encodings (NONE=0, LW=1, LB=2, LBU=3, SW=4, SB=5) and state encodings SHALL live in the shared defines package.
REQ-018 Lane select, byte replication and load extension SHALL be a combinational sub-module named mem_byte_lane.

Verification
REQ-019 ALU op, mem_wdata=0x12345678, wd=3, wreg=1 -> next cycle wb_wdata=0x12345678, wb_wd=3, wb_wreg=1, stallreq never 1.
REQ-020 LW at 0x100, bus_ready after 3 wait cycles, rdata=0xDEADBEEF -> stallreq high 4 cycles, bus_sel=1111, wb_wdata=0xDEADBEEF.
REQ-021 LB and LBU at 0x101, rdata=0x00800000 -> bus_sel=0100; wb_wdata=0xFFFFFF80 (LB), 0x00000080 (LBU).
REQ-022 SB at 0x103, mem_wdata=0x000000AB -> bus_we=1, bus_sel=0001, bus_wdata=0xABABABAB, wb_wreg=0.
REQ-023 rst=0 mid-ACCESS, then bus_ready=1 -> bus_req=0 at once, no write-back, IDLE after release.
REQ-024 With MEM_ALIGN_CHECK_EN, LW at 0x102 -> bus_req stays 0, align_err 1-cycle pulse, wb_wreg=0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared definitions for the memory-access stage.
//   - register bus / register address widths and reset constants
//   - mem_op encodings (NONE, LW, LB, LBU, SW, SB) and FSM state encodings
//   - decode_op: maps any raw 3-bit op code onto a defined op (undefined -> NONE)
package mem_access_pkg;

  localparam int unsigned RegisterBus        = 32;
  localparam int unsigned RegisterAddressBus = 5;

  localparam logic [RegisterBus-1:0]        ZeroWord           = '0;
  localparam logic [RegisterAddressBus-1:0] NOPRegisterAddress = '0;
  localparam logic                          WriteDisable       = 1'b0;
  localparam logic                          WriteEnable        = 1'b1;

  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_LW   = 3'd1,
    MEM_LB   = 3'd2,
    MEM_LBU  = 3'd3,
    MEM_SW   = 3'd4,
    MEM_SB   = 3'd5
  } mem_op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  function automatic mem_op_e decode_op(input logic [2:0] raw);
    mem_op_e op;
    case (raw)
      3'd1:    op = MEM_LW;
      3'd2:    op = MEM_LB;
      3'd3:    op = MEM_LBU;
      3'd4:    op = MEM_SW;
      3'd5:    op = MEM_SB;
      default: op = MEM_NONE;
    endcase
    return op;
  endfunction

  function automatic logic is_load(input mem_op_e op);
    return (op == MEM_LW) || (op == MEM_LB) || (op == MEM_LBU);
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return (op == MEM_SW) || (op == MEM_SB);
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// mem_byte_lane: combinational byte-lane logic (big-endian lanes).
//   op        in  3   raw memory op code
//   offset    in  2   byte offset within the word (addr[1:0])
//   wdata_in  in  32  store data from the pipeline
//   rdata_in  in  32  read data from the bus
//   sel       out 4   byte-lane select (offset 00 -> 1000 ... 11 -> 0001, words 1111)
//   wdata_out out 32  bus store data (SB replicates the low byte to all lanes)
//   rdata_out out 32  load result (LW raw, LB sign-extended, LBU zero-extended)
module mem_byte_lane
  import mem_access_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  sel,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);

  mem_op_e     op_d;
  logic [3:0]  byte_sel;
  logic [7:0]  lane_byte;

  always_comb begin
    op_d      = decode_op(op);
    byte_sel  = 4'b1000;
    lane_byte = rdata_in[31:24];
    case (offset)
      2'b00: begin byte_sel = 4'b1000; lane_byte = rdata_in[31:24]; end
      2'b01: begin byte_sel = 4'b0100; lane_byte = rdata_in[23:16]; end
      2'b10: begin byte_sel = 4'b0010; lane_byte = rdata_in[15:8];  end
      default: begin byte_sel = 4'b0001; lane_byte = rdata_in[7:0]; end
    endcase

    sel       = '0;
    wdata_out = wdata_in;
    rdata_out = ZeroWord;
    case (op_d)
      MEM_LW: begin
        sel       = '1;
        rdata_out = rdata_in;
      end
      MEM_LB: begin
        sel       = byte_sel;
        rdata_out = {{24{lane_byte[7]}}, lane_byte};
      end
      MEM_LBU: begin
        sel       = byte_sel;
        rdata_out = {24'h000000, lane_byte};
      end
      MEM_SW: begin
        sel = '1;
      end
      MEM_SB: begin
        sel       = byte_sel;
        wdata_out = {4{wdata_in[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage with a registered data-bus master.
//   clk, rst            clock; asynchronous active-low reset
//   mem_wdata/wd/wreg   EX/MEM result, destination address, write enable
//   mem_op, mem_addr    memory op code and effective byte address
//   bus_req/we/addr/sel/wdata  registered data-bus request (word address, big-endian lanes)
//   bus_ready, bus_rdata       bus completion and read data
//   wb_wdata/wd/wreg    registered write-back result
//   stallreq            combinational stall request to upstream
//   align_err           registered one-cycle misalignment pulse
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned LW/SW
// (no bus access, align_err pulse); otherwise align_err is tied low.
module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_wdata,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [2:0]  mem_op,
  input  logic [31:0] mem_addr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic [31:0] wb_wdata,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic        stallreq,
  output logic        align_err
);

  state_e      state;
  mem_op_e     op_in;
  mem_op_e     op_q;
  logic [1:0]  off_q;
  logic [4:0]  wd_q;
  logic        wreg_q;
  logic        mem_valid;
  logic        misaligned;

  mem_op_e     lane_op;
  logic [1:0]  lane_off;
  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  assign op_in     = decode_op(mem_op);
  assign mem_valid = (op_in != MEM_NONE);

`ifdef MEM_ALIGN_CHECK_EN
  logic align_q;
  assign misaligned = ((op_in == MEM_LW) || (op_in == MEM_SW)) && (mem_addr[1:0] != 2'b00);
  assign align_err  = align_q;
`else
  assign misaligned = 1'b0;
  assign align_err  = 1'b0;
`endif

  // One lane block serves both phases: in IDLE it shapes the outgoing request
  // from the live inputs, in ACCESS it extracts the load result using the op
  // and offset captured at issue, so upstream need not hold its inputs.
  assign lane_op  = (state == ST_IDLE) ? op_in : op_q;
  assign lane_off = (state == ST_IDLE) ? mem_addr[1:0] : off_q;

  mem_byte_lane u_lane (
    .op        (lane_op),
    .offset    (lane_off),
    .wdata_in  (mem_wdata),
    .rdata_in  (bus_rdata),
    .sel       (lane_sel),
    .wdata_out (lane_wdata),
    .rdata_out (lane_rdata)
  );

  always_comb begin
    stallreq = 1'b0;
    case (state)
      ST_IDLE:   stallreq = mem_valid && !misaligned;
      ST_ACCESS: stallreq = !bus_ready;
      default:   stallreq = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_sel   <= '0;
      bus_wdata <= '0;
      wb_wdata  <= ZeroWord;
      wb_wd     <= NOPRegisterAddress;
      wb_wreg   <= WriteDisable;
      op_q      <= MEM_NONE;
      off_q     <= '0;
      wd_q      <= NOPRegisterAddress;
      wreg_q    <= WriteDisable;
`ifdef MEM_ALIGN_CHECK_EN
      align_q   <= 1'b0;
`endif
    end else begin
`ifdef MEM_ALIGN_CHECK_EN
      align_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (misaligned) begin
            wb_wreg <= WriteDisable;
`ifdef MEM_ALIGN_CHECK_EN
            align_q <= 1'b1;
`endif
          end else if (mem_valid) begin
            bus_req   <= 1'b1;
            bus_we    <= is_store(op_in);
            bus_addr  <= {mem_addr[31:2], 2'b00};
            bus_sel   <= lane_sel;
            bus_wdata <= lane_wdata;
            wb_wreg   <= WriteDisable;
            op_q      <= op_in;
            off_q     <= mem_addr[1:0];
            wd_q      <= mem_wd;
            wreg_q    <= mem_wreg;
            state     <= ST_ACCESS;
          end else begin
            wb_wdata <= mem_wdata;
            wb_wd    <= mem_wd;
            wb_wreg  <= mem_wreg;
          end
        end
        ST_ACCESS: begin
          if (bus_ready) begin
            bus_req  <= 1'b0;
            bus_we   <= 1'b0;
            wb_wdata <= lane_rdata;
            wb_wd    <= wd_q;
            wb_wreg  <= is_load(op_q) ? wreg_q : WriteDisable;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
`timescale 1ns/1ps
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_wdata;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [2:0]  mem_op;
  logic [31:0] mem_addr;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic [31:0] wb_wdata;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic        stallreq;
  logic        align_err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk       (clk),
    .rst       (rst),
    .mem_wdata (mem_wdata),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_op    (mem_op),
    .mem_addr  (mem_addr),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_sel   (bus_sel),
    .bus_wdata (bus_wdata),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata),
    .wb_wdata  (wb_wdata),
    .wb_wd     (wb_wd),
    .wb_wreg   (wb_wreg),
    .stallreq  (stallreq),
    .align_err (align_err)
  );

  // Observations of one bus transaction, filled by run_access.
  int          o_stall;
  logic        o_req;
  logic        o_we;
  logic [31:0] o_addr;
  logic [3:0]  o_sel;
  logic [31:0] o_wdata;
  logic        o_stable;
  logic        o_bubble;
  logic        o_align;
  logic [31:0] o_wb_wdata;
  logic [4:0]  o_wb_wd;
  logic        o_wb_wreg;
  logic        o_req_after;
  logic        o_we_after;

  // Acts as upstream pipeline plus bus slave: presents a memory op, answers
  // after 'waits' not-ready cycles, then advances upstream to NONE.
  task automatic run_access(input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] wd,
                            input logic wreg, input logic [31:0] rdata,
                            input int waits);
    o_stall = 0; o_stable = 1'b1; o_bubble = 1'b1; o_align = 1'b0;
    mem_op = op; mem_addr = addr; mem_wdata = wdata; mem_wd = wd; mem_wreg = wreg;
    bus_ready = 1'b0; bus_rdata = $urandom;
    #1;
    if (stallreq === 1'b1) o_stall++;
    @(posedge clk); #1;
    o_req = bus_req; o_we = bus_we; o_addr = bus_addr; o_sel = bus_sel; o_wdata = bus_wdata;
    if (wb_wreg !== 1'b0) o_bubble = 1'b0;
    if (align_err !== 1'b0) o_align = 1'b1;
    if (bus_req !== 1'b1) begin
      mem_op = 3'd0; mem_wreg = 1'b0;
      return;
    end
    for (int i = 0; i < waits; i++) begin
      if (stallreq === 1'b1) o_stall++;
      @(posedge clk); #1;
      if (bus_req !== 1'b1 || bus_we !== o_we || bus_addr !== o_addr ||
          bus_sel !== o_sel || bus_wdata !== o_wdata) o_stable = 1'b0;
      if (wb_wreg !== 1'b0) o_bubble = 1'b0;
    end
    bus_ready = 1'b1; bus_rdata = rdata;
    #1;
    if (stallreq === 1'b1) o_stall++;
    @(posedge clk); #1;
    o_wb_wdata = wb_wdata; o_wb_wd = wb_wd; o_wb_wreg = wb_wreg;
    o_req_after = bus_req; o_we_after = bus_we;
    bus_ready = 1'b0; bus_rdata = $urandom;
    mem_op = 3'd0; mem_wreg = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; mem_op = 3'd0; mem_addr = $urandom; mem_wdata = $urandom;
    mem_wd = 5'd17; mem_wreg = 1'b1; bus_ready = 1'b0; bus_rdata = $urandom;
    #2;
    n_cmp++;
    if ({bus_req, bus_we, bus_addr, bus_sel, bus_wdata} !== {1'b0, 1'b0, 32'h0, 4'h0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_bus: got req=%b we=%b addr=%h sel=%b wdata=%h, want all zero",
               bus_req, bus_we, bus_addr, bus_sel, bus_wdata);
    end
    n_cmp++;
    if ({wb_wdata, wb_wd, wb_wreg, align_err} !== {32'h0, 5'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_wb: got wdata=%h wd=%0d wreg=%b align=%b, want 0/0/0/0",
               wb_wdata, wb_wd, wb_wreg, align_err);
    end
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_passthrough;
    mem_op = 3'd0; mem_wdata = 32'h12345678; mem_wd = 5'd3; mem_wreg = 1'b1;
    #1;
    n_cmp++;
    if (stallreq !== 1'b0) begin
      n_bad++; $display("FAIL alu_stall: got %b want 0", stallreq);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({wb_wdata, wb_wd, wb_wreg} !== {32'h12345678, 5'd3, 1'b1}) begin
      n_bad++;
      $display("FAIL alu_wb: got %h/%0d/%b want 12345678/3/1", wb_wdata, wb_wd, wb_wreg);
    end
    n_cmp++;
    if (stallreq !== 1'b0 || bus_req !== 1'b0) begin
      n_bad++; $display("FAIL alu_nobus: got stall=%b req=%b want 0/0", stallreq, bus_req);
    end
  endtask

  task automatic test_lw_wait;
    run_access(3'd1, 32'h0000_0100, 32'h0, 5'd8, 1'b1, 32'hDEADBEEF, 3);
    n_cmp++;
    if (o_req !== 1'b1) begin
      n_bad++; $display("FAIL lw_req: got %b want 1 (no request issued)", o_req);
    end else begin
      n_cmp++;
      if ({o_we, o_addr, o_sel} !== {1'b0, 32'h100, 4'b1111}) begin
        n_bad++; $display("FAIL lw_bus: got we=%b addr=%h sel=%b want 0/100/1111", o_we, o_addr, o_sel);
      end
      n_cmp++;
      if (o_stall !== 4) begin
        n_bad++; $display("FAIL lw_stall_cycles: got %0d want 4", o_stall);
      end
      n_cmp++;
      if (o_stable !== 1'b1 || o_bubble !== 1'b1) begin
        n_bad++; $display("FAIL lw_hold: got stable=%b bubble=%b want 1/1", o_stable, o_bubble);
      end
      n_cmp++;
      if ({o_wb_wdata, o_wb_wd, o_wb_wreg, o_req_after} !== {32'hDEADBEEF, 5'd8, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL lw_wb: got %h/%0d/%b req=%b want deadbeef/8/1 req=0",
                 o_wb_wdata, o_wb_wd, o_wb_wreg, o_req_after);
      end
    end
  endtask

  task automatic test_lb_lbu;
    logic [2:0]  ops [2];
    logic [31:0] want [2];
    ops[0] = 3'd2; want[0] = 32'hFFFFFF80;
    ops[1] = 3'd3; want[1] = 32'h00000080;
    for (int k = 0; k < 2; k++) begin
      run_access(ops[k], 32'h0000_0101, 32'h0, 5'd12, 1'b1, 32'h00800000, 1);
      n_cmp++;
      if ({o_req, o_addr, o_sel} !== {1'b1, 32'h100, 4'b0100}) begin
        n_bad++; $display("FAIL byte_load_bus op=%0d: got req=%b addr=%h sel=%b want 1/100/0100",
                          ops[k], o_req, o_addr, o_sel);
      end
      n_cmp++;
      if ({o_wb_wdata, o_wb_wreg} !== {want[k], 1'b1}) begin
        n_bad++; $display("FAIL byte_load_wb op=%0d: got %h/%b want %h/1",
                          ops[k], o_wb_wdata, o_wb_wreg, want[k]);
      end
    end
  endtask

  task automatic test_sb;
    run_access(3'd5, 32'h0000_0103, 32'h000000AB, 5'd4, 1'b1, 32'h0, 2);
    n_cmp++;
    if ({o_req, o_we, o_sel, o_wdata} !== {1'b1, 1'b1, 4'b0001, 32'hABABABAB}) begin
      n_bad++; $display("FAIL sb_bus: got req=%b we=%b sel=%b wdata=%h want 1/1/0001/abababab",
                        o_req, o_we, o_sel, o_wdata);
    end
    n_cmp++;
    if ({o_wb_wreg, o_we_after, o_req_after} !== 3'b000) begin
      n_bad++; $display("FAIL sb_wb: got wreg=%b we=%b req=%b want 0/0/0", o_wb_wreg, o_we_after, o_req_after);
    end
  endtask

  task automatic test_reset_mid_access;
    mem_op = 3'd1; mem_addr = 32'h200; mem_wd = 5'd7; mem_wreg = 1'b1; bus_ready = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (bus_req !== 1'b1) begin
      n_bad++; $display("FAIL midrst_start: got req=%b want 1", bus_req);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus_req, bus_we, bus_sel, bus_addr, wb_wreg} !== {1'b0, 1'b0, 4'h0, 32'h0, 1'b0}) begin
      n_bad++; $display("FAIL midrst_abort: got req=%b we=%b sel=%b addr=%h wreg=%b want all 0",
                        bus_req, bus_we, bus_sel, bus_addr, wb_wreg);
    end
    mem_op = 3'd0; mem_wreg = 1'b0;
    bus_ready = 1'b1; bus_rdata = 32'h5555AAAA;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus_req, wb_wreg} !== 2'b00 || wb_wdata === 32'h5555AAAA) begin
      n_bad++; $display("FAIL midrst_late_ready: got req=%b wreg=%b wdata=%h want 0/0/not 5555aaaa",
                        bus_req, wb_wreg, wb_wdata);
    end
    bus_ready = 1'b0;
    mem_wdata = 32'h0000CAFE; mem_wd = 5'd9; mem_wreg = 1'b1;
    #1;
    n_cmp++;
    if (stallreq !== 1'b0) begin
      n_bad++; $display("FAIL midrst_idle_stall: got %b want 0", stallreq);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({wb_wdata, wb_wd, wb_wreg} !== {32'h0000CAFE, 5'd9, 1'b1}) begin
      n_bad++; $display("FAIL midrst_idle: got %h/%0d/%b want 0000cafe/9/1", wb_wdata, wb_wd, wb_wreg);
    end
  endtask

  task automatic test_align;
    mem_op = 3'd1; mem_addr = 32'h102; mem_wd = 5'd5; mem_wreg = 1'b1; bus_ready = 1'b0;
    #1;
`ifdef MEM_ALIGN_CHECK_EN
    n_cmp++;
    if (stallreq !== 1'b0) begin
      n_bad++; $display("FAIL align_stall: got %b want 0", stallreq);
    end
    @(posedge clk); #1;
    mem_op = 3'd0; mem_wreg = 1'b0;
    n_cmp++;
    if ({bus_req, align_err, wb_wreg} !== 3'b010) begin
      n_bad++; $display("FAIL align_pulse: got req=%b align=%b wreg=%b want 0/1/0", bus_req, align_err, wb_wreg);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (align_err !== 1'b0 || bus_req !== 1'b0) begin
      n_bad++; $display("FAIL align_one_cycle: got align=%b req=%b want 0/0", align_err, bus_req);
    end
`else
    mem_op = 3'd0;
    run_access(3'd1, 32'h102, 32'h0, 5'd5, 1'b1, 32'h01020304, 0);
    n_cmp++;
    if ({o_req, o_addr, o_sel, o_align, o_wb_wdata} !== {1'b1, 32'h100, 4'b1111, 1'b0, 32'h01020304}) begin
      n_bad++; $display("FAIL word_offset_ignored: got req=%b addr=%h sel=%b align=%b wb=%h want 1/100/1111/0/01020304",
                        o_req, o_addr, o_sel, o_align, o_wb_wdata);
    end
`endif
  endtask

  // Random ops (including undefined codes) against a spec-level model.
  task automatic test_random;
    for (int n = 0; n < 60; n++) begin
      logic [2:0]  op;
      logic [31:0] addr, wdata, rdata, exp_res, exp_wdata;
      logic [4:0]  wd;
      logic        wreg, exp_we, exp_wreg, word_op, bad_align;
      logic [3:0]  exp_sel;
      logic [7:0]  b;
      int          off, waits;
      op = 3'($urandom_range(0, 7));
      addr = $urandom; wdata = $urandom; rdata = $urandom;
      wd = 5'($urandom); wreg = 1'($urandom); waits = $urandom_range(0, 3);
      off = int'(addr[1:0]);
      b = 8'((rdata >> (8 * (3 - off))) & 32'hFF);
      word_op = (op == 3'd1) || (op == 3'd4);
`ifdef MEM_ALIGN_CHECK_EN
      bad_align = word_op && (off != 0);
`else
      bad_align = 1'b0;
`endif
      exp_sel   = word_op ? 4'b1111 : 4'(4'b1000 >> off);
      exp_we    = (op == 3'd4) || (op == 3'd5);
      exp_wdata = (op == 3'd5) ? (32'h01010101 * {24'h0, wdata[7:0]}) : wdata;
      exp_res   = (op == 3'd1) ? rdata :
                  (op == 3'd2) ? ((b >= 8'd128) ? ({24'h0, b} | 32'hFFFFFF00) : {24'h0, b}) :
                  {24'h0, b};
      exp_wreg  = exp_we ? 1'b0 : wreg;
      if (op == 3'd0 || op > 3'd5 || bad_align) begin
        mem_op = op; mem_addr = addr; mem_wdata = wdata; mem_wd = wd; mem_wreg = wreg;
        #1;
        n_cmp++;
        if (stallreq !== 1'b0) begin
          n_bad++; $display("FAIL rnd_nostall #%0d op=%0d: got %b want 0", n, op, stallreq);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bad_align) begin
          if ({bus_req, wb_wreg, align_err} !== 3'b001) begin
            n_bad++; $display("FAIL rnd_misalign #%0d: got req=%b wreg=%b align=%b want 0/0/1",
                              n, bus_req, wb_wreg, align_err);
          end
        end else if ({wb_wdata, wb_wd, wb_wreg, bus_req, align_err} !== {wdata, wd, wreg, 1'b0, 1'b0}) begin
          n_bad++; $display("FAIL rnd_none #%0d op=%0d: got %h/%0d/%b req=%b want %h/%0d/%b req=0",
                            n, op, wb_wdata, wb_wd, wb_wreg, bus_req, wdata, wd, wreg);
        end
        mem_op = 3'd0; mem_wreg = 1'b0;
      end else begin
        run_access(op, addr, wdata, wd, wreg, rdata, waits);
        n_cmp++;
        if ({o_req, o_we, o_addr, o_sel, o_align} !== {1'b1, exp_we, addr & 32'hFFFFFFFC, exp_sel, 1'b0}) begin
          n_bad++; $display("FAIL rnd_bus #%0d op=%0d: got req=%b we=%b addr=%h sel=%b want 1/%b/%h/%b",
                            n, op, o_req, o_we, o_addr, o_sel, exp_we, addr & 32'hFFFFFFFC, exp_sel);
        end else begin
          n_cmp++;
          if (exp_we && o_wdata !== exp_wdata) begin
            n_bad++; $display("FAIL rnd_store_data #%0d: got %h want %h", n, o_wdata, exp_wdata);
          end
          n_cmp++;
          if (o_stall !== waits + 1 || o_stable !== 1'b1 || o_bubble !== 1'b1) begin
            n_bad++; $display("FAIL rnd_handshake #%0d: got stall=%0d stable=%b bubble=%b want %0d/1/1",
                              n, o_stall, o_stable, o_bubble, waits + 1);
          end
          n_cmp++;
          if (o_wb_wreg !== exp_wreg || o_req_after !== 1'b0 || o_we_after !== 1'b0 ||
              (!exp_we && (o_wb_wdata !== exp_res || o_wb_wd !== wd))) begin
            n_bad++; $display("FAIL rnd_wb #%0d op=%0d: got %h/%0d/%b req=%b want %h/%0d/%b req=0",
                              n, op, o_wb_wdata, o_wb_wd, o_wb_wreg, o_req_after, exp_res, wd, exp_wreg);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_alu_passthrough;
    test_lw_wait;
    test_lb_lbu;
    test_sb;
    test_reset_mid_access;
    test_align;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
